// File: rtl/gemm_out_arbiter.sv
// gemm_out_arbiter
//   Round-robin arbiter and nibble serializer for the GEMM kernel's result
//   streams. Each channel buffers one word. Granted words are emitted as a
//   frame: one header nibble {0, channel}, then DW/OW data nibbles, LSB first.
//
// Ports
//   ap_clk      clock
//   ap_rst      synchronous active-high reset
//   ch_din      per-channel write data, channel k at [k*DW +: DW]
//   ch_write    per-channel write strobe
//   ch_full_n   per-channel ready (hold register empty)
//   data_out    serialized header/data nibble (registered)
//   data_valid  data_out is meaningful (registered)
//   data_first  header nibble marker (registered)
//   probe_out   running XOR parity of all accepted words (registered)
module gemm_out_arbiter #(
    parameter int unsigned N_CH = 8,
    parameter int unsigned DW   = 32,
    parameter int unsigned OW   = 4
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [N_CH*DW-1:0] ch_din,
    input  logic [N_CH-1:0]    ch_write,
    output logic [N_CH-1:0]    ch_full_n,
    output logic [OW-1:0]      data_out,
    output logic               data_valid,
    output logic               data_first,
    output logic               probe_out
);

    localparam int unsigned NNIB = DW / OW;
    localparam int unsigned CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int unsigned IW   = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StShift} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     hold_q [N_CH];
    logic [N_CH-1:0]   hold_valid_q, hold_valid_d;
    logic [DW-1:0]     shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [OW-1:0]     data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              data_first_q, data_first_d;
    logic              probe_q, probe_d;

    logic [N_CH-1:0]   acc;
    logic              acc_par;
    logic              gnt_found;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     cand;
    logic              take;

    assign ch_full_n = ~hold_valid_q;
    assign acc       = ch_write & ~hold_valid_q;

    // Parity contribution of every word accepted at this edge.
    always_comb begin
        acc_par = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (acc[k]) begin
                acc_par = acc_par ^ (^ch_din[k*DW +: DW]);
            end
        end
    end

    // First pending channel searching upward from last+1, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = IW'((32'(last_q) + i) % N_CH);
            if (!gnt_found && hold_valid_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Output registers carry the value of the state being entered, so the
    // header appears the cycle after the grant edge.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        data_out_d   = '0;
        data_valid_d = 1'b0;
        data_first_d = 1'b0;
        take         = 1'b0;

        unique case (state_q)
            StIdle: begin
                take = gnt_found;
            end
            StHdr: begin
                state_d      = StShift;
                cnt_d        = '0;
                data_out_d   = shreg_q[OW-1:0];
                data_valid_d = 1'b1;
                shreg_d      = shreg_q >> OW;
            end
            StShift: begin
                if (cnt_q == CW'(NNIB - 1)) begin
                    if (gnt_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d        = cnt_q + 1'b1;
                    data_out_d   = shreg_q[OW-1:0];
                    data_valid_d = 1'b1;
                    shreg_d      = shreg_q >> OW;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (take) begin
            state_d      = StHdr;
            shreg_d      = hold_q[gnt_idx];
            last_d       = gnt_idx;
            data_out_d   = {{(OW-IW){1'b0}}, gnt_idx};
            data_valid_d = 1'b1;
            data_first_d = 1'b1;
        end
    end

    // Accept and grant never hit the same channel: a grant needs the hold
    // register full, which blocks acceptance.
    always_comb begin
        hold_valid_d = hold_valid_q | acc;
        if (take) begin
            hold_valid_d[gnt_idx] = 1'b0;
        end
    end

    assign probe_d = probe_q ^ acc_par;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= StIdle;
            hold_valid_q <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            last_q       <= IW'(N_CH - 1);
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            data_first_q <= 1'b0;
            probe_q      <= 1'b0;
            for (int k = 0; k < int'(N_CH); k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_first_q <= data_first_d;
            probe_q      <= probe_d;
            for (int k = 0; k < int'(N_CH); k++) begin
                if (acc[k]) begin
                    hold_q[k] <= ch_din[k*DW +: DW];
                end
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign data_first = data_first_q;
    assign probe_out  = probe_q;

endmodule

// File: tb/tb_gemm_out_arbiter.sv
// Directed testbench for gemm_out_arbiter. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_gemm_out_arbiter;

    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic [255:0] ch_din;
    logic [7:0]   ch_write;
    logic [7:0]   ch_full_n;
    logic [3:0]   data_out;
    logic         data_valid;
    logic         data_first;
    logic         probe_out;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_probe;

    always #5 ap_clk = ~ap_clk;

    gemm_out_arbiter #(
        .N_CH(8),
        .DW  (32),
        .OW  (4)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ch_din    (ch_din),
        .ch_write  (ch_write),
        .ch_full_n (ch_full_n),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_first(data_first),
        .probe_out (probe_out)
    );

    task automatic do_reset();
        ap_rst   = 1'b1;
        ch_write = '0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst    = 1'b0;
        exp_probe = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst   = 1'b1;
        ch_write = 8'hFF;
        ch_din   = {8{32'hDEAD_BEEF}};
        repeat (3) begin
            @(negedge ap_clk);
            n_vec++;
            if ({data_valid, data_out, probe_out, ch_full_n} !== {1'b0, 4'h0, 1'b0, 8'hFF}) begin
                n_err++;
                $display("FAIL reset_hold: got v=%b d=%h p=%b f=%h want v=0 d=0 p=0 f=ff",
                         data_valid, data_out, probe_out, ch_full_n);
            end
        end
        ap_rst    = 1'b0;
        ch_write  = '0;
        exp_probe = 1'b0;
        repeat (12) begin
            @(negedge ap_clk);
            n_vec++;
            if ({data_valid, data_first, probe_out, ch_full_n} !== {1'b0, 1'b0, 1'b0, 8'hFF}) begin
                n_err++;
                $display("FAIL reset_release: got v=%b fst=%b p=%b f=%h want v=0 fst=0 p=0 f=ff",
                         data_valid, data_first, probe_out, ch_full_n);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'h8765_4321;
        @(negedge ap_clk);
        ch_din[5*32 +: 32] = w;
        ch_write           = 8'h20;
        exp_probe          = exp_probe ^ (^w);
        @(negedge ap_clk);
        ch_write = '0;
        n_vec++;
        if ({data_valid, ch_full_n} !== {1'b0, 8'hDF}) begin
            n_err++;
            $display("FAIL single_full: got v=%b f=%h want v=0 f=df", data_valid, ch_full_n);
        end
        @(negedge ap_clk);
        n_vec++;
        if ({data_valid, data_first, data_out, ch_full_n} !== {1'b1, 1'b1, 4'h5, 8'hFF}) begin
            n_err++;
            $display("FAIL single_hdr: got v=%b fst=%b d=%h f=%h want v=1 fst=1 d=5 f=ff",
                     data_valid, data_first, data_out, ch_full_n);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            n_vec++;
            if ({data_valid, data_first, data_out} !== {1'b1, 1'b0, w[i*4 +: 4]}) begin
                n_err++;
                $display("FAIL single_nib%0d: got v=%b fst=%b d=%h want v=1 fst=0 d=%h",
                         i, data_valid, data_first, data_out, w[i*4 +: 4]);
            end
        end
        @(negedge ap_clk);
        n_vec++;
        if ({data_valid, probe_out} !== {1'b0, exp_probe}) begin
            n_err++;
            $display("FAIL single_end: got v=%b p=%b want v=0 p=%b",
                     data_valid, probe_out, exp_probe);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            ch_din[k*32 +: 32] = 32'(k);
            exp_probe          = exp_probe ^ (^(32'(k)));
        end
        ch_write = 8'hFF;
        @(negedge ap_clk);
        ch_write = '0;
        n_vec++;
        if (ch_full_n !== 8'h00) begin
            n_err++;
            $display("FAIL rr_full: got f=%h want f=00", ch_full_n);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            n_vec++;
            if ({data_valid, data_first, data_out} !== {1'b1, 1'b1, 4'(k)}) begin
                n_err++;
                $display("FAIL rr_hdr%0d: got v=%b fst=%b d=%h want v=1 fst=1 d=%h",
                         k, data_valid, data_first, data_out, 4'(k));
            end
            for (int i = 0; i < 8; i++) begin
                @(negedge ap_clk);
                n_vec++;
                if ({data_valid, data_first, data_out} !==
                    {1'b1, 1'b0, (i == 0) ? 4'(k) : 4'h0}) begin
                    n_err++;
                    $display("FAIL rr_ch%0d_nib%0d: got v=%b fst=%b d=%h want v=1 fst=0 d=%h",
                             k, i, data_valid, data_first, data_out,
                             (i == 0) ? 4'(k) : 4'h0);
                end
            end
        end
        @(negedge ap_clk);
        n_vec++;
        if ({data_valid, probe_out} !== {1'b0, exp_probe}) begin
            n_err++;
            $display("FAIL rr_end: got v=%b p=%b want v=0 p=%b", data_valid, probe_out, exp_probe);
        end
    endtask

    task automatic test_fairness();
        logic [31:0] w1;
        logic [31:0] w6;
        logic [3:0]  hdrs [$];
        logic [3:0]  exp_hdr [5];
        logic        saw_full0;
        int          gaps;
        int          wait_cyc;
        w1        = 32'h1111_0001;
        w6        = 32'h6666_0006;
        exp_hdr   = '{4'h1, 4'h6, 4'h1, 4'h1, 4'h1};
        saw_full0 = 1'b0;
        gaps      = 0;
        @(negedge ap_clk);
        ch_din[1*32 +: 32] = w1;
        ch_din[6*32 +: 32] = w6;
        ch_write           = 8'h02;
        exp_probe          = exp_probe ^ (^w1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge ap_clk);
            if (data_first) hdrs.push_back(data_out);
            if (!ch_full_n[1]) saw_full0 = 1'b1;
            if (cyc >= 2 && !data_valid) gaps++;
            ch_write = '0;
            if (cyc < 30 && ch_full_n[1]) begin
                ch_write[1] = 1'b1;
                exp_probe   = exp_probe ^ (^w1);
            end
            if (cyc == 4) begin
                ch_write[6] = 1'b1;
                exp_probe   = exp_probe ^ (^w6);
            end
        end
        ch_write = '0;
        n_vec++;
        if (hdrs.size() < 5) begin
            n_err++;
            $display("FAIL fair_count: got %0d headers want at least 5", hdrs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (hdrs[i] !== exp_hdr[i]) begin
                    n_err++;
                    $display("FAIL fair_hdr%0d: got %h want %h", i, hdrs[i], exp_hdr[i]);
                end
            end
        end
        n_vec++;
        if (saw_full0 !== 1'b1) begin
            n_err++;
            $display("FAIL fair_full1: got saw_full0=%b want 1", saw_full0);
        end
        n_vec++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL fair_gaps: got %0d idle cycles want 0", gaps);
        end
        wait_cyc = 0;
        while (data_valid === 1'b1 && wait_cyc < 30) begin
            @(negedge ap_clk);
            wait_cyc++;
        end
        n_vec++;
        if (data_valid !== 1'b0 || probe_out !== exp_probe) begin
            n_err++;
            $display("FAIL fair_drain: got v=%b p=%b want v=0 p=%b",
                     data_valid, probe_out, exp_probe);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0;
        logic [31:0] wa;
        logic [31:0] wb;
        w0 = 32'h0000_00C1;
        wa = 32'h3333_0A07;
        wb = 32'h0000_0001;
        @(negedge ap_clk);
        ch_din[0*32 +: 32] = w0;
        ch_write           = 8'h01;
        exp_probe          = exp_probe ^ (^w0);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge ap_clk);
            if (cyc == 1) ch_write = '0;
            if (cyc == 2) begin
                n_vec++;
                if ({data_valid, data_first, data_out} !== {1'b1, 1'b1, 4'h0}) begin
                    n_err++;
                    $display("FAIL bp_hdr0: got v=%b fst=%b d=%h want v=1 fst=1 d=0",
                             data_valid, data_first, data_out);
                end
            end
            if (cyc == 3) begin
                ch_din[3*32 +: 32] = wa;
                ch_write           = 8'h08;
                exp_probe          = exp_probe ^ (^wa);
            end
            if (cyc == 4) begin
                n_vec++;
                if (ch_full_n[3] !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_full3: got %b want 0", ch_full_n[3]);
                end
                ch_din[3*32 +: 32] = wb;
                ch_write           = 8'h08;
            end
            if (cyc == 5) ch_write = '0;
            if (cyc == 11) begin
                n_vec++;
                if ({data_valid, data_first, data_out} !== {1'b1, 1'b1, 4'h3}) begin
                    n_err++;
                    $display("FAIL bp_hdr3: got v=%b fst=%b d=%h want v=1 fst=1 d=3",
                             data_valid, data_first, data_out);
                end
            end
            if (cyc >= 12 && cyc <= 19) begin
                n_vec++;
                if ({data_valid, data_out} !== {1'b1, wa[(cyc-12)*4 +: 4]}) begin
                    n_err++;
                    $display("FAIL bp_nib%0d: got v=%b d=%h want v=1 d=%h",
                             cyc - 12, data_valid, data_out, wa[(cyc-12)*4 +: 4]);
                end
            end
            if (cyc >= 20) begin
                n_vec++;
                if (data_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_idle%0d: got v=%b want v=0", cyc, data_valid);
                end
            end
        end
        n_vec++;
        if (probe_out !== exp_probe) begin
            n_err++;
            $display("FAIL bp_probe: got %b want %b", probe_out, exp_probe);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0;
        logic [31:0] w7;
        w0 = 32'h9876_5432;
        w7 = 32'h0000_0007;
        @(negedge ap_clk);
        ch_din[0*32 +: 32] = w0;
        ch_write           = 8'h01;
        for (int cyc = 1; cyc <= 28; cyc++) begin
            @(negedge ap_clk);
            if (cyc == 1) begin
                ch_din[2*32 +: 32] = 32'h2222_2222;
                ch_din[4*32 +: 32] = 32'h4444_4444;
                ch_write           = 8'h14;
            end
            if (cyc == 2) ch_write = '0;
            if (cyc == 7) begin
                n_vec++;
                if ({data_valid, data_first, data_out} !== {1'b1, 1'b0, w0[16 +: 4]}) begin
                    n_err++;
                    $display("FAIL rm_nib4: got v=%b fst=%b d=%h want v=1 fst=0 d=%h",
                             data_valid, data_first, data_out, w0[16 +: 4]);
                end
                ap_rst = 1'b1;
            end
            if (cyc == 8) begin
                n_vec++;
                if ({data_valid, data_out, probe_out, ch_full_n} !==
                    {1'b0, 4'h0, 1'b0, 8'hFF}) begin
                    n_err++;
                    $display("FAIL rm_reset: got v=%b d=%h p=%b f=%h want v=0 d=0 p=0 f=ff",
                             data_valid, data_out, probe_out, ch_full_n);
                end
                ap_rst             = 1'b0;
                exp_probe          = ^w7;
                ch_din[7*32 +: 32] = w7;
                ch_write           = 8'h80;
            end
            if (cyc == 9) begin
                ch_write = '0;
                n_vec++;
                if (data_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rm_gap: got v=%b want v=0", data_valid);
                end
            end
            if (cyc == 10) begin
                n_vec++;
                if ({data_valid, data_first, data_out} !== {1'b1, 1'b1, 4'h7}) begin
                    n_err++;
                    $display("FAIL rm_hdr7: got v=%b fst=%b d=%h want v=1 fst=1 d=7",
                             data_valid, data_first, data_out);
                end
            end
            if (cyc >= 11 && cyc <= 18) begin
                n_vec++;
                if ({data_valid, data_out} !== {1'b1, w7[(cyc-11)*4 +: 4]}) begin
                    n_err++;
                    $display("FAIL rm_nib%0d: got v=%b d=%h want v=1 d=%h",
                             cyc - 11, data_valid, data_out, w7[(cyc-11)*4 +: 4]);
                end
            end
            if (cyc >= 19) begin
                n_vec++;
                if (data_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rm_idle%0d: got v=%b want v=0", cyc, data_valid);
                end
            end
        end
        n_vec++;
        if (probe_out !== exp_probe) begin
            n_err++;
            $display("FAIL rm_probe: got %b want %b", probe_out, exp_probe);
        end
    endtask

    initial begin
        ap_rst    = 1'b1;
        ch_write  = '0;
        ch_din    = '0;
        exp_probe = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
